// File: rtl/bitserial_column_sequencer.sv
// Operand latch and bit-column sequencer feeding the bit-serial precompute MAC.
// Issues weight bit-columns LSB first (optionally skipping all-zero columns), then drains the MAC.

module bitserial_column_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int ACC_WIDTH  = DATA_WIDTH + 16,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] w_in         [VEC_LENGTH],
    input  logic signed [DATA_WIDTH-1:0] act_in       [VEC_LENGTH],
    input  logic signed [ACC_WIDTH-1:0]  accum_init,
    output logic                         mac_en,
    output logic                         mac_load_accum,
    output logic signed [DATA_WIDTH-1:0] mac_act      [VEC_LENGTH],
    output logic signed [DATA_WIDTH:0]   mac_act_psum [VEC_LENGTH/2],
    output logic [VEC_LENGTH-1:0]        mac_w_bit,
    output logic [2:0]                   mac_column_idx,
    output logic                         mac_is_msb,
    output logic signed [ACC_WIDTH-1:0]  mac_accum_prev,
    output logic                         busy,
    output logic                         result_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef logic [DATA_WIDTH-1:0] mask_t;

    function automatic logic [2:0] lowest_set(input mask_t m);
        logic [2:0] idx;
        idx = '0;
        for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
            if (m[b]) idx = 3'(b);
        end
        return idx;
    endfunction

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  w_q    [VEC_LENGTH];
    logic signed [DATA_WIDTH-1:0]  w_d    [VEC_LENGTH];
    logic signed [DATA_WIDTH-1:0]  act_q  [VEC_LENGTH];
    logic signed [DATA_WIDTH-1:0]  act_d  [VEC_LENGTH];
    logic signed [DATA_WIDTH:0]    psum_q [VEC_LENGTH/2];
    logic signed [DATA_WIDTH:0]    psum_d [VEC_LENGTH/2];
    logic signed [ACC_WIDTH-1:0]   accum_q, accum_d;
    mask_t                         mask_q, mask_d;
    logic                          first_q, first_d;
    logic                          en_q, en_d;
    logic                          load_q, load_d;
    logic [VEC_LENGTH-1:0]         w_bit_q, w_bit_d;
    logic [2:0]                    col_q, col_d;
    logic                          msb_q, msb_d;
    logic                          rv_q, rv_d;

    logic                          issue;
    mask_t                         issue_mask;
    mask_t                         nz;
    logic [2:0]                    col_sel;
    logic signed [DATA_WIDTH-1:0]  issue_w [VEC_LENGTH];

    // mask_q holds the columns still to issue after the one currently on the outputs.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        act_d      = act_q;
        psum_d     = psum_q;
        accum_d    = accum_q;
        mask_d     = mask_q;
        first_d    = 1'b0;
        load_d     = first_q;
        en_d       = 1'b0;
        w_bit_d    = '0;
        col_d      = '0;
        msb_d      = 1'b0;
        rv_d       = 1'b0;
        issue      = 1'b0;
        issue_mask = '0;
        issue_w    = w_q;
        nz         = '0;
        col_sel    = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = w_in;
                    act_d   = act_in;
                    accum_d = accum_init;
                    for (int j = 0; j < VEC_LENGTH / 2; j++) begin
                        psum_d[j] = $signed({act_in[2*j][DATA_WIDTH-1], act_in[2*j]})
                                  + $signed({act_in[2*j+1][DATA_WIDTH-1], act_in[2*j+1]});
                    end
                    for (int i = 0; i < VEC_LENGTH; i++) begin
                        nz = nz | mask_t'(w_in[i]);
                    end
                    issue_mask = SKIP_ZERO ? nz : '1;
                    if (issue_mask == '0) issue_mask = mask_t'(1);
                    issue_w = w_in;
                    issue   = 1'b1;
                    first_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mask_q == '0) begin
                    en_d    = 1'b1;
                    state_d = DRAIN;
                end else begin
                    issue_mask = mask_q;
                    issue      = 1'b1;
                end
            end
            DRAIN: begin
                rv_d    = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            col_sel = lowest_set(issue_mask);
            en_d    = 1'b1;
            col_d   = col_sel;
            msb_d   = (int'(col_sel) == DATA_WIDTH - 1);
            mask_d  = issue_mask & ~(mask_t'(1) << col_sel);
            for (int i = 0; i < VEC_LENGTH; i++) begin
                w_bit_d[i] = issue_w[i][col_sel];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int i = 0; i < VEC_LENGTH; i++) begin
                w_q[i]   <= '0;
                act_q[i] <= '0;
            end
            for (int j = 0; j < VEC_LENGTH / 2; j++) begin
                psum_q[j] <= '0;
            end
            accum_q <= '0;
            mask_q  <= '0;
            first_q <= 1'b0;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            w_bit_q <= '0;
            col_q   <= '0;
            msb_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            act_q   <= act_d;
            psum_q  <= psum_d;
            accum_q <= accum_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            en_q    <= en_d;
            load_q  <= load_d;
            w_bit_q <= w_bit_d;
            col_q   <= col_d;
            msb_q   <= msb_d;
            rv_q    <= rv_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign mac_en         = en_q;
    assign mac_load_accum = load_q;
    assign mac_act        = act_q;
    assign mac_act_psum   = psum_q;
    assign mac_w_bit      = w_bit_q;
    assign mac_column_idx = col_q;
    assign mac_is_msb     = msb_q;
    assign mac_accum_prev = accum_q;
    assign result_valid   = rv_q;

endmodule

// File: tb/tb_bitserial_column_sequencer.sv
// Self-checking bench: a column-list model predicts every output cycle, and a small MAC
// model integrates the issued columns so the final dot product can be checked.

module tb_bitserial_column_sequencer;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int AW = DW + 16;

    typedef struct packed {
        logic          en;
        logic          load;
        logic [VL-1:0] wbit;
        logic [2:0]    col;
        logic          msb;
        logic          rv;
        logic          ready;
        logic          busy;
    } ctl_t;

    logic                  clk;
    logic                  reset;
    logic [1:0]            valid;
    logic signed [DW-1:0]  wIn   [VL];
    logic signed [DW-1:0]  actIn [VL];
    logic signed [AW-1:0]  accumInit;

    logic                  rdy0, en0, load0, msb0, busy0, rv0;
    logic signed [DW-1:0]  act0  [VL];
    logic signed [DW:0]    psum0 [VL/2];
    logic [VL-1:0]         wbit0;
    logic [2:0]            col0;
    logic signed [AW-1:0]  prev0;

    logic                  rdy1, en1, load1, msb1, busy1, rv1;
    logic signed [DW-1:0]  act1  [VL];
    logic signed [DW:0]    psum1 [VL/2];
    logic [VL-1:0]         wbit1;
    logic [2:0]            col1;
    logic signed [AW-1:0]  prev1;

    bitserial_column_sequencer #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .SKIP_ZERO(1'b1)
    ) dutSkip (
        .clk(clk), .reset(reset), .in_valid(valid[0]), .in_ready(rdy0),
        .w_in(wIn), .act_in(actIn), .accum_init(accumInit),
        .mac_en(en0), .mac_load_accum(load0), .mac_act(act0), .mac_act_psum(psum0),
        .mac_w_bit(wbit0), .mac_column_idx(col0), .mac_is_msb(msb0),
        .mac_accum_prev(prev0), .busy(busy0), .result_valid(rv0)
    );

    bitserial_column_sequencer #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .SKIP_ZERO(1'b0)
    ) dutAll (
        .clk(clk), .reset(reset), .in_valid(valid[1]), .in_ready(rdy1),
        .w_in(wIn), .act_in(actIn), .accum_init(accumInit),
        .mac_en(en1), .mac_load_accum(load1), .mac_act(act1), .mac_act_psum(psum1),
        .mac_w_bit(wbit1), .mac_column_idx(col1), .mac_is_msb(msb1),
        .mac_accum_prev(prev1), .busy(busy1), .result_valid(rv1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ctl_t                  expQ [2][$];
    logic signed [DW-1:0]  mdlAct  [2][VL];
    logic signed [DW:0]    mdlPsum [2][VL/2];
    longint                mdlPrev [2];
    longint                mdlDot  [2];
    longint                macc [2];
    longint                mprod [2];
    int                    accCnt [2], rvCnt [2], accCycle [2], prevAccCycle [2];
    int                    rvOff [2], loadOff [2], enCnt [2], issueLast [2];
    longint                lastResult [2];
    int                    tests, fails;
    bit                    started;

    ctl_t                  cur [2];
    ctl_t                  expc;
    logic [127:0]          va, ve;
    logic signed [DW-1:0]  snapAct  [2][VL];
    logic signed [DW:0]    snapPsum [2][VL/2];
    longint                snapPrev [2];
    longint                term;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic checkValue(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic ctl_t mkCtl(input logic en, input logic load, input logic [VL-1:0] wbit,
                                   input logic [2:0] col, input logic msb, input logic rv,
                                   input logic ready, input logic bsy);
        ctl_t c;
        c.en = en; c.load = load; c.wbit = wbit; c.col = col;
        c.msb = msb; c.rv = rv; c.ready = ready; c.busy = bsy;
        return c;
    endfunction

    // Predict the whole cycle sequence of one vector from the columns it must visit.
    task automatic acceptModel(input int u);
        int            cols [$];
        bit            nzc;
        logic [VL-1:0] wb;
        longint        dot;
        for (int c = 0; c < DW; c++) begin
            nzc = 1'b0;
            for (int i = 0; i < VL; i++) if (wIn[i][c]) nzc = 1'b1;
            if (nzc || u == 1) cols.push_back(c);
        end
        if (cols.size() == 0) cols.push_back(0);
        dot = longint'(accumInit);
        for (int i = 0; i < VL; i++) begin
            mdlAct[u][i] = actIn[i];
            dot += longint'(wIn[i]) * longint'(actIn[i]);
        end
        for (int j = 0; j < VL / 2; j++) mdlPsum[u][j] = 9'(int'(actIn[2*j]) + int'(actIn[2*j+1]));
        mdlPrev[u] = longint'(accumInit);
        mdlDot[u]  = dot;
        for (int k = 0; k < cols.size(); k++) begin
            for (int i = 0; i < VL; i++) wb[i] = wIn[i][cols[k]];
            expQ[u].push_back(mkCtl(1'b1, k == 1, wb, 3'(cols[k]), cols[k] == DW - 1, 1'b0, 1'b0, 1'b1));
        end
        expQ[u].push_back(mkCtl(1'b1, cols.size() == 1, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        expQ[u].push_back(mkCtl(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        prevAccCycle[u] = accCycle[u];
        accCycle[u]     = cyc;
        accCnt[u]++;
        enCnt[u] = 0;
    endtask

    always @(negedge clk) begin
        if (started) begin
            cur[0] = mkCtl(en0, load0, wbit0, col0, msb0, rv0, rdy0, busy0);
            cur[1] = mkCtl(en1, load1, wbit1, col1, msb1, rv1, rdy1, busy1);
            for (int i = 0; i < VL; i++) begin
                snapAct[0][i] = act0[i];
                snapAct[1][i] = act1[i];
            end
            for (int j = 0; j < VL / 2; j++) begin
                snapPsum[0][j] = psum0[j];
                snapPsum[1][j] = psum1[j];
            end
            snapPrev[0] = longint'(prev0);
            snapPrev[1] = longint'(prev1);
            for (int u = 0; u < 2; u++) begin
                if (!reset) begin
                    expQ[u].delete();
                    for (int i = 0; i < VL; i++) mdlAct[u][i] = '0;
                    for (int j = 0; j < VL / 2; j++) mdlPsum[u][j] = '0;
                    mdlPrev[u] = 0;
                    expc = mkCtl(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                end else if (expQ[u].size() > 0) begin
                    expc = expQ[u].pop_front();
                end else begin
                    expc = mkCtl(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                end
                va = '0; ve = '0;
                va[$bits(ctl_t)-1:0] = cur[u];
                ve[$bits(ctl_t)-1:0] = expc;
                checkOutput($sformatf("ctl u%0d", u), va, ve);
                for (int i = 0; i < VL; i++) begin
                    va[i*DW +: DW] = snapAct[u][i];
                    ve[i*DW +: DW] = mdlAct[u][i];
                end
                checkOutput($sformatf("mac_act u%0d", u), va, ve);
                va = '0; ve = '0;
                for (int j = 0; j < VL / 2; j++) begin
                    va[j*(DW+1) +: DW+1] = snapPsum[u][j];
                    ve[j*(DW+1) +: DW+1] = mdlPsum[u][j];
                end
                checkOutput($sformatf("mac_act_psum u%0d", u), va, ve);
                checkValue($sformatf("mac_accum_prev u%0d", u), snapPrev[u], mdlPrev[u]);
                if (reset) begin
                    if (cur[u].en) begin
                        term = 0;
                        for (int i = 0; i < VL; i++) if (cur[u].wbit[i]) term += longint'(snapAct[u][i]);
                        term = term * (longint'(1) << cur[u].col);
                        if (cur[u].msb) term = -term;
                        macc[u]  = (cur[u].load ? snapPrev[u] : macc[u]) + mprod[u];
                        mprod[u] = term;
                        enCnt[u]++;
                    end
                    if (cur[u].load) loadOff[u] = cyc - accCycle[u];
                    if (cur[u].rv) begin
                        rvCnt[u]++;
                        rvOff[u]      = cyc - accCycle[u];
                        issueLast[u]  = enCnt[u] - 1;
                        lastResult[u] = macc[u];
                        checkValue($sformatf("accum u%0d", u), macc[u], mdlDot[u]);
                    end
                    if (expc.ready && valid[u]) acceptModel(u);
                end
            end
        end
    end

    task automatic applyStimulus(input int u, input int kind, input int count);
        int start;
        @(posedge clk);
        #1;
        for (int i = 0; i < VL; i++) begin
            case (kind)
                0: begin wIn[i] = 8'sd0;        actIn[i] = 8'sd5; end
                1: begin wIn[i] = 8'sd1;        actIn[i] = 8'(i); end
                2: begin wIn[i] = -8'sd1;       actIn[i] = 8'sd1; end
                3: begin wIn[i] = 8'sh41;       actIn[i] = 8'sd2; end
                4: begin wIn[i] = 8'(i - 8);    actIn[i] = 8'(3 * i - 20); end
                default: begin wIn[i] = 8'sd1;  actIn[i] = 8'(i); end
            endcase
        end
        accumInit = (kind == 4) ? 24'sd1000 : (kind == 5) ? -24'sd50 : 24'sd0;
        start    = accCnt[u];
        valid[u] = 1'b1;
        for (int k = 0; k < 40 * count && accCnt[u] - start < count; k++) @(posedge clk);
        #1;
        valid[u] = 1'b0;
        checkValue($sformatf("accept count u%0d", u), accCnt[u] - start, count);
    endtask

    task automatic waitResult(input int u, input int target);
        for (int k = 0; k < 40 && rvCnt[u] < target; k++) @(posedge clk);
        checkValue($sformatf("result seen u%0d", u), rvCnt[u], target);
        repeat (2) @(posedge clk);
    endtask

    int r;

    initial begin
        tests = 0; fails = 0; started = 1'b0;
        clk = 1'b0; reset = 1'b1; valid = '0; accumInit = '0;
        for (int i = 0; i < VL; i++) begin
            wIn[i] = '0; actIn[i] = '0;
        end
        for (int u = 0; u < 2; u++) begin
            accCnt[u] = 0; rvCnt[u] = 0; accCycle[u] = 0; prevAccCycle[u] = 0; rvOff[u] = 0;
            loadOff[u] = 0; enCnt[u] = 0; issueLast[u] = 0; lastResult[u] = 0;
            macc[u] = 0; mprod[u] = 0; mdlDot[u] = 0; mdlPrev[u] = 0;
        end
        #2 reset = 1'b0;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero weights: one forced column 0.
        r = rvCnt[0];
        applyStimulus(0, 0, 1);
        waitResult(0, r + 1);
        checkValue("t1 issues", issueLast[0], 1);
        checkValue("t1 result offset", rvOff[0], 3);
        checkValue("t1 result", lastResult[0], 0);

        // Unit weights, ramp activations.
        r = rvCnt[0];
        applyStimulus(0, 1, 1);
        for (int j = 0; j < VL / 2; j++) checkValue($sformatf("t2 psum%0d", j), longint'(psum0[j]), 4 * j + 1);
        waitResult(0, r + 1);
        checkValue("t2 issues", issueLast[0], 1);
        checkValue("t2 result", lastResult[0], 120);

        // All -1 weights: every column, sign column last.
        r = rvCnt[0];
        applyStimulus(0, 2, 1);
        waitResult(0, r + 1);
        checkValue("t3 issues", issueLast[0], 8);
        checkValue("t3 load offset", loadOff[0], 2);
        checkValue("t3 result offset", rvOff[0], 10);
        checkValue("t3 result", lastResult[0], -16);

        // 0x41 weights with and without zero-column skipping.
        r = rvCnt[1];
        applyStimulus(1, 3, 1);
        waitResult(1, r + 1);
        checkValue("t4 noskip issues", issueLast[1], 8);
        checkValue("t4 noskip result offset", rvOff[1], 10);
        checkValue("t4 noskip result", lastResult[1], 2080);
        r = rvCnt[0];
        applyStimulus(0, 3, 1);
        waitResult(0, r + 1);
        checkValue("t4 skip issues", issueLast[0], 2);
        checkValue("t4 skip result offset", rvOff[0], 4);
        checkValue("t4 skip result", lastResult[0], 2080);

        // Back-to-back vectors with in_valid held high.
        r = rvCnt[0];
        applyStimulus(0, 4, 2);
        waitResult(0, r + 2);
        checkValue("t5 acceptance gap", accCycle[0] - prevAccCycle[0], 11);

        // Reset in the third issue cycle aborts the vector.
        applyStimulus(0, 2, 1);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        r = rvCnt[0];
        #1;
        checkValue("t6 mac_en in reset", en0, 0);
        checkValue("t6 busy in reset", busy0, 0);
        checkValue("t6 in_ready in reset", rdy0, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (12) @(posedge clk);
        checkValue("t6 no result after abort", rvCnt[0] - r, 0);

        // Recovery vector after the abort.
        r = rvCnt[0];
        applyStimulus(0, 5, 1);
        waitResult(0, r + 1);
        checkValue("t7 issues", issueLast[0], 1);
        checkValue("t7 result", lastResult[0], 70);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
